difftest_commit_probe: RTL and testbench

Parametrised successor to the single-shot DPI register/PC probe. It sits between the core's commit stage and the simulation difftest harness. Each retired instruction is buffered in a commit FIFO and drained to the harness over a valid/ready channel. The block keeps a shadow GPR file that is updated at drain time and detects ebreak halt and no-commit timeout.

---
 rtl/difftest_commit_probe.sv | 183 ++++++++++++++++++
 tb/tb_difftest_commit_probe.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/difftest_commit_probe.sv
// Commit probe between the core's retire stage and the difftest harness: buffers retired
// instructions, drains them over valid/ready, tracks shadow GPRs, ebreak halt and a no-commit watchdog.
module difftest_commit_probe #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned NR_REG      = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TIMEOUT_CYC = 4096,
  parameter int unsigned A0_IDX      = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      commit_valid,
  output logic                      commit_ready,
  input  logic [XLEN-1:0]           commit_pc,
  input  logic [31:0]               commit_inst,
  input  logic                      commit_wen,
  input  logic [$clog2(NR_REG)-1:0] commit_wdest,
  input  logic [XLEN-1:0]           commit_wdata,
  input  logic                      commit_ebreak,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_pc,
  output logic [31:0]               out_inst,
  output logic                      out_wen,
  output logic [$clog2(NR_REG)-1:0] out_wdest,
  output logic [XLEN-1:0]           out_wdata,
  output logic                      out_ebreak,
  output logic [NR_REG*XLEN-1:0]    gpr_flat,
  output logic [63:0]               commit_cnt,
  output logic                      halt,
  output logic [XLEN-1:0]           halt_code,
  output logic                      timeout
);

  localparam int unsigned W_IDX = $clog2(NR_REG);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned WD_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT, ST_TIMEOUT} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic [WD_W-1:0]     r_wd_cnt;
  logic [63:0]         r_commit_cnt;
  logic [XLEN-1:0]     r_halt_code;
  logic [XLEN-1:0]     r_gpr     [NR_REG];
  logic [XLEN-1:0]     r_pc_q    [DEPTH];
  logic [31:0]         r_inst_q  [DEPTH];
  logic                r_wen_q   [DEPTH];
  logic [W_IDX-1:0]    r_wdest_q [DEPTH];
  logic [XLEN-1:0]     r_wdata_q [DEPTH];
  logic                r_eb_q    [DEPTH];

  logic                w_push;
  logic                w_pop;
  logic                w_wd_fire;
  logic                w_a0_hit;
  logic [XLEN-1:0]     w_a0_nxt;

  assign commit_ready = (r_state == ST_RUN) && (r_count < CNT_W'(DEPTH));
  assign out_valid    = (r_count != '0);
  assign w_push       = commit_valid && commit_ready;
  assign w_pop        = out_valid && out_ready;

  assign out_pc     = r_pc_q[r_rd_ptr];
  assign out_inst   = r_inst_q[r_rd_ptr];
  assign out_wen    = r_wen_q[r_rd_ptr];
  assign out_wdest  = r_wdest_q[r_rd_ptr];
  assign out_wdata  = r_wdata_q[r_rd_ptr];
  assign out_ebreak = r_eb_q[r_rd_ptr];

  assign commit_cnt = r_commit_cnt;
  assign halt_code  = r_halt_code;
  assign halt       = (r_state == ST_HALT);
  assign timeout    = (r_state == ST_TIMEOUT);

  // A push in the same cycle the watchdog saturates suppresses the timeout.
  assign w_wd_fire = (TIMEOUT_CYC != 0) && (r_wd_cnt == WD_W'(TIMEOUT_CYC)) && !w_push;

  // halt_code must reflect an a0 write retired by the ebreak pop itself.
  assign w_a0_hit = out_wen && (out_wdest == W_IDX'(A0_IDX)) && (out_wdest != '0);
  assign w_a0_nxt = w_a0_hit ? out_wdata : r_gpr[W_IDX'(A0_IDX)];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_push && commit_ebreak) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_wd_fire) begin
          w_state_nxt = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (w_pop && out_ebreak) begin
          w_state_nxt = ST_HALT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Payload storage needs no reset; visibility is governed by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]    <= commit_pc;
      r_inst_q[r_wr_ptr]  <= commit_inst;
      r_wen_q[r_wr_ptr]   <= commit_wen;
      r_wdest_q[r_wr_ptr] <= commit_wdest;
      r_wdata_q[r_wr_ptr] <= commit_wdata;
      r_eb_q[r_wr_ptr]    <= commit_ebreak;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (r_state == ST_RUN) begin
      if (w_push) begin
        r_wd_cnt <= '0;
      end else if (r_wd_cnt != WD_W'(TIMEOUT_CYC)) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NR_REG; i++) begin
        r_gpr[i] <= '0;
      end
    end else if (w_pop && out_wen && (out_wdest != '0)) begin
      r_gpr[out_wdest] <= out_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_commit_cnt <= '0;
      r_halt_code  <= '0;
    end else begin
      if (w_pop) begin
        r_commit_cnt <= r_commit_cnt + 64'd1;
      end
      if ((r_state == ST_DRAIN) && w_pop && out_ebreak) begin
        r_halt_code <= w_a0_nxt;
      end
    end
  end

  for (genvar g = 0; g < NR_REG; g++) begin : g_gpr_flat
    assign gpr_flat[g*XLEN +: XLEN] = r_gpr[g];
  end

endmodule

// File: tb/tb_difftest_commit_probe.sv
// Scoreboard bench for difftest_commit_probe: expected entries queued at issue,
// a negedge monitor checks every drained entry; directed checks cover GPRs, halt and watchdog.
module tb_difftest_commit_probe;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          commit_valid;
  logic          commit_ready;
  logic [63:0]   commit_pc;
  logic [31:0]   commit_inst;
  logic          commit_wen;
  logic [4:0]    commit_wdest;
  logic [63:0]   commit_wdata;
  logic          commit_ebreak;
  logic          out_valid;
  logic          out_ready;
  logic [63:0]   out_pc;
  logic [31:0]   out_inst;
  logic          out_wen;
  logic [4:0]    out_wdest;
  logic [63:0]   out_wdata;
  logic          out_ebreak;
  logic [32*64-1:0] gpr_flat;
  logic [63:0]   commit_cnt;
  logic          halt;
  logic [63:0]   halt_code;
  logic          timeout;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        wen;
    logic [4:0]  wdest;
    logic [63:0] wdata;
    logic        eb;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int   n_checks = 0;
  int   n_errs   = 0;

  difftest_commit_probe #(
    .XLEN(64), .NR_REG(32), .DEPTH(4), .TIMEOUT_CYC(16), .A0_IDX(10)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .commit_pc(commit_pc), .commit_inst(commit_inst), .commit_wen(commit_wen),
    .commit_wdest(commit_wdest), .commit_wdata(commit_wdata), .commit_ebreak(commit_ebreak),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .out_wen(out_wen), .out_wdest(out_wdest),
    .out_wdata(out_wdata), .out_ebreak(out_ebreak),
    .gpr_flat(gpr_flat), .commit_cnt(commit_cnt),
    .halt(halt), .halt_code(halt_code), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] gpr(input int i);
    return gpr_flat[i*64 +: 64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    commit_valid  = 1'b0;
    commit_pc     = '0;
    commit_inst   = '0;
    commit_wen    = 1'b0;
    commit_wdest  = '0;
    commit_wdata  = '0;
    commit_ebreak = 1'b0;
    out_ready     = 1'b0;
    sb.delete();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] inst_of(input logic [63:0] pc, input logic eb);
    return eb ? 32'h0010_0073 : (32'h0000_0013 ^ pc[31:0]);
  endfunction

  task automatic drive(input logic [63:0] pc, input logic [4:0] wd, input logic [63:0] data,
                       input logic wen, input logic eb);
    commit_valid  = 1'b1;
    commit_pc     = pc;
    commit_inst   = inst_of(pc, eb);
    commit_wen    = wen;
    commit_wdest  = wd;
    commit_wdata  = data;
    commit_ebreak = eb;
  endtask

  // Offer one commit, wait (bounded) for acceptance, record expected entry.
  task automatic push_c(input logic [63:0] pc, input logic [4:0] wd, input logic [63:0] data,
                        input logic wen, input logic eb);
    int waited = 0;
    drive(pc, wd, data, wen, eb);
    while (!commit_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!commit_ready) begin
      n_checks++;
      n_errs++;
      $display("FAIL push_wait: commit_ready got 0 required 1 for pc 0x%0h", pc);
    end else begin
      sb.push_back('{pc: pc, inst: inst_of(pc, eb), wen: wen, wdest: wd, wdata: data, eb: eb});
      tick();
    end
    commit_valid  = 1'b0;
    commit_ebreak = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while (out_valid && waited < 20) begin
      tick();
      waited++;
    end
    check({name, "_drained"}, 64'(out_valid), 64'd0);
    check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic wait_flag(input string name, input int which);
    int waited = 0;
    while (((which == 0) ? !halt : !timeout) && waited < 25) begin
      tick();
      waited++;
    end
    check(name, 64'((which == 0) ? halt : timeout), 64'd1);
  endtask

  // Scoreboard monitor: every handshake on the output side must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL pop_unexpected: got pc 0x%0h required no entry", out_pc);
      end else begin
        mon_e = sb.pop_front();
        check("out_pc", out_pc, mon_e.pc);
        check("out_inst", 64'(out_inst), 64'(mon_e.inst));
        check("out_wdata", out_wdata, mon_e.wdata);
        check("out_flags", 64'({out_wen, out_wdest, out_ebreak}),
              64'({mon_e.wen, mon_e.wdest, mon_e.eb}));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got simulation still running required finish");
    $fatal(1);
  end

  initial begin
    // Reset state and first-entry latency
    do_reset();
    check("rst_ready", 64'(commit_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_cnt", commit_cnt, 64'd0);
    check("rst_halt", 64'(halt), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_halt_code", halt_code, 64'd0);
    out_ready = 1'b1;
    drive(64'h8000_0000, 5'd1, 64'h11, 1'b1, 1'b0);
    check("no_bypass", 64'(out_valid), 64'd0);
    push_c(64'h8000_0000, 5'd1, 64'h11, 1'b1, 1'b0);
    check("lat1_valid", 64'(out_valid), 64'd1);
    push_c(64'h8000_0004, 5'd2, 64'h22, 1'b1, 1'b0);
    push_c(64'h8000_0008, 5'd3, 64'h33, 1'b1, 1'b0);
    wait_drain("t1");
    check("t1_gpr1", gpr(1), 64'h11);
    check("t1_gpr2", gpr(2), 64'h22);
    check("t1_gpr3", gpr(3), 64'h33);
    check("t1_cnt", commit_cnt, 64'd3);

    // Backpressure: fill, hold the fifth, then drain across pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_c(64'h100 + 64'(4*i), 5'(5 + i), 64'hA0 + 64'(i), 1'b1, 1'b0);
    end
    check("full_ready", 64'(commit_ready), 64'd0);
    drive(64'h110, 5'd9, 64'hA4, 1'b1, 1'b0);
    tick(); tick(); tick();
    check("held_ready", 64'(commit_ready), 64'd0);
    check("held_head_pc", out_pc, 64'h100);
    check("held_cnt", commit_cnt, 64'd0);
    out_ready = 1'b1;
    push_c(64'h110, 5'd9, 64'hA4, 1'b1, 1'b0);
    wait_drain("t2");
    check("t2_cnt", commit_cnt, 64'd5);
    for (int i = 0; i < 5; i++) begin
      check("t2_gpr", gpr(5 + i), 64'hA0 + 64'(i));
    end

    // x0 write dropped but still counted
    push_c(64'h200, 5'd0, 64'hdead, 1'b1, 1'b0);
    wait_drain("t3");
    check("x0_zero", gpr(0), 64'd0);
    check("x0_cnt", commit_cnt, 64'd6);

    // ebreak with a0=0, held by out_ready=0
    do_reset();
    push_c(64'h300, 5'd10, 64'h0, 1'b1, 1'b0);
    push_c(64'h304, 5'd0, 64'h0, 1'b0, 1'b1);
    check("drain_ready", 64'(commit_ready), 64'd0);
    tick(); tick();
    check("drain_no_halt", 64'(halt), 64'd0);
    out_ready = 1'b1;
    wait_flag("halt_a0_0", 0);
    check("halt_code_0", halt_code, 64'd0);
    check("halt_cnt", commit_cnt, 64'd2);
    check("halt_no_timeout", 64'(timeout), 64'd0);
    check("halt_ready", 64'(commit_ready), 64'd0);

    // ebreak accepted with concurrent pop, a0=1
    do_reset();
    out_ready = 1'b1;
    push_c(64'h400, 5'd10, 64'h1, 1'b1, 1'b0);
    push_c(64'h404, 5'd0, 64'h0, 1'b0, 1'b1);
    wait_flag("halt_a0_1", 0);
    check("halt_code_1", halt_code, 64'd1);

    // ebreak entry itself writes a0: halt_code sees that write
    do_reset();
    out_ready = 1'b1;
    push_c(64'h500, 5'd10, 64'h7, 1'b1, 1'b0);
    push_c(64'h504, 5'd10, 64'h5a5, 1'b1, 1'b1);
    wait_flag("halt_a0_same", 0);
    check("halt_code_same", halt_code, 64'h5a5);
    check("halt_gpr10", gpr(10), 64'h5a5);

    // Watchdog: idle after reset fires at cycle 17
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    check("wd_16", 64'(timeout), 64'd0);
    tick();
    check("wd_17", 64'(timeout), 64'd1);
    check("wd_no_halt", 64'(halt), 64'd0);
    check("wd_ready", 64'(commit_ready), 64'd0);

    // Push on the saturating cycle wins; then timeout still drains
    do_reset();
    for (int i = 0; i < 16; i++) tick();
    push_c(64'h600, 5'd6, 64'h66, 1'b1, 1'b0);
    check("wd_push_wins", 64'(timeout), 64'd0);
    check("wd_push_ready", 64'(commit_ready), 64'd1);
    wait_flag("wd_refire", 1);
    out_ready = 1'b1;
    wait_drain("t_wd");
    check("wd_drain_cnt", commit_cnt, 64'd1);
    check("wd_drain_gpr6", gpr(6), 64'h66);

    // Reset while draining with two entries queued
    do_reset();
    out_ready = 1'b1;
    push_c(64'h700, 5'd4, 64'h44, 1'b1, 1'b0);
    tick();
    check("pre_rst_gpr4", gpr(4), 64'h44);
    out_ready = 1'b0;
    push_c(64'h704, 5'd5, 64'h55, 1'b1, 1'b0);
    push_c(64'h708, 5'd0, 64'h0, 1'b0, 1'b1);
    check("pre_rst_drain", 64'(commit_ready), 64'd0);
    do_reset();
    check("post_rst_valid", 64'(out_valid), 64'd0);
    check("post_rst_gpr4", gpr(4), 64'd0);
    check("post_rst_ready", 64'(commit_ready), 64'd1);
    check("post_rst_cnt", commit_cnt, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
